// File: rtl/adc_mv_bcd_if.sv
// Sample/display handshake between the ADC reader, the mV converter
// and the seven-segment display driver.
interface adc_mv_bcd_if;
    logic [7:0]  adc_data;
    logic        adc_valid;
    logic        busy;
    logic [31:0] dsp_data;
    logic        dsp_valid;

    modport master (
        output adc_data, adc_valid,
        input  busy, dsp_data, dsp_valid
    );

    modport slave (
        input  adc_data, adc_valid,
        output busy, dsp_data, dsp_valid
    );
endinterface

// File: rtl/adc_mv_bcd.sv
// Raw 8-bit ADC code -> rounded millivolts -> BCD display word, using
// one multiply, a serial divide by 255 and serial double-dabble.
module adc_mv_bcd #(
    parameter int VREF_MV  = 3300,
    parameter bit SHOW_RAW = 1'b1
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    adc_mv_bcd_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, MUL, DIV, BCD, DONE} state_t;

    localparam logic [19:0] VREF    = 20'(VREF_MV);
    localparam logic [8:0]  DIVISOR = 9'd255;

    state_t      state;
    logic [7:0]  raw_q;
    logic [19:0] prod;
    logic [7:0]  rem;
    logic [4:0]  cnt;
    logic [15:0] bcd;
    logic [11:0] bin;
    logic [31:0] dsp_data;
    logic        dsp_valid;
    logic        busy;

    logic [8:0]  trial;
    logic        ge;
    logic [8:0]  diff;
    logic [15:0] adj;

    // The dividend shifts out of prod MSB-first while quotient bits shift in
    // at the bottom, so prod ends up holding the quotient.
    always_comb begin
        trial = {rem, prod[19]};
        ge    = (trial >= DIVISOR);
        diff  = trial - DIVISOR;
        adj   = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            raw_q     <= '0;
            prod      <= '0;
            rem       <= '0;
            cnt       <= '0;
            bcd       <= '0;
            bin       <= '0;
            dsp_data  <= '0;
            dsp_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            dsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.adc_valid) begin
                        raw_q <= bus.adc_data;
                        rem   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= MUL;
                    end
                end
                MUL: begin
                    prod  <= 20'(raw_q) * VREF + 20'd127;
                    state <= DIV;
                end
                DIV: begin
                    rem  <= ge ? diff[7:0] : trial[7:0];
                    prod <= {prod[18:0], ge};
                    cnt  <= cnt + 5'd1;
                    if (cnt == 5'd19) begin
                        bin   <= {prod[10:0], ge};
                        bcd   <= '0;
                        cnt   <= '0;
                        state <= BCD;
                    end
                end
                BCD: begin
                    bcd <= {adj[14:0], bin[11]};
                    bin <= {bin[10:0], 1'b0};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd11)
                        state <= DONE;
                end
                DONE: begin
                    dsp_data  <= {SHOW_RAW ? raw_q : 8'h00, 8'h00, bcd};
                    dsp_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dsp_data  = dsp_data;
    assign bus.dsp_valid = dsp_valid;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_adc_mv_bcd.sv
// Scoreboard bench for adc_mv_bcd: two instances (3300 mV with raw code,
// 4095 mV without) share one randomized stimulus stream.
module tb_adc_mv_bcd;
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_data;
    logic       a_valid;
    int         cyc = 0;
    int         last_acc = -1000;
    int         passed = 0;
    int         total = 0;
    exp_t       q0[$];
    exp_t       q1[$];

    adc_mv_bcd_if b0();
    adc_mv_bcd_if b1();

    assign b0.adc_data  = a_data;
    assign b0.adc_valid = a_valid;
    assign b1.adc_data  = a_data;
    assign b1.adc_valid = a_valid;

    adc_mv_bcd #(.VREF_MV(3300), .SHOW_RAW(1'b1)) dut0 (
        .sys_clk(clk), .sys_rst(rst), .bus(b0)
    );
    adc_mv_bcd #(.VREF_MV(4095), .SHOW_RAW(1'b0)) dut1 (
        .sys_clk(clk), .sys_rst(rst), .bus(b1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_word(int c, int vref, bit show);
        int mv;
        mv = (c * vref + 127) / 255;
        return {show ? 8'(c) : 8'h00, 8'h00,
                4'(mv / 1000), 4'((mv / 100) % 10),
                4'((mv / 10) % 10), 4'(mv % 10)};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at cycle %0d",
                      name, act, exp, cyc);
    endtask

    // Accepted only if the previous accepted sample is at least 35 cycles old.
    task automatic strobe(input logic [7:0] code);
        exp_t e;
        a_data  = code;
        a_valid = 1'b1;
        if (cyc >= last_acc + 35) begin
            last_acc = cyc;
            e.cyc  = cyc + 35;
            e.data = ref_word(int'(code), 3300, 1'b1);
            q0.push_back(e);
            e.data = ref_word(int'(code), 4095, 1'b0);
            q1.push_back(e);
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_data  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic exp_busy;
        if (!rst) begin
            exp_busy = (cyc >= last_acc + 1) && (cyc <= last_acc + 34);
            check("busy0", 32'(b0.busy), 32'(exp_busy));
            check("busy1", 32'(b1.busy), 32'(exp_busy));
            if (b0.dsp_valid) begin
                if (q0.size() == 0) begin
                    total++;
                    $display("FAIL spurious_valid0: got data %h, none expected",
                             b0.dsp_data);
                end else begin
                    e = q0.pop_front();
                    check("data0", b0.dsp_data, e.data);
                    check("latency0", 32'(cyc), 32'(e.cyc));
                end
            end
            if (b1.dsp_valid) begin
                if (q1.size() == 0) begin
                    total++;
                    $display("FAIL spurious_valid1: got data %h, none expected",
                             b1.dsp_data);
                end else begin
                    e = q1.pop_front();
                    check("data1", b1.dsp_data, e.data);
                    check("latency1", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        int k;
        rst     = 1'b1;
        a_valid = 1'b0;
        a_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_data0", b0.dsp_data, 32'h0);
        check("rst_valid0", 32'(b0.dsp_valid), 32'h0);
        check("rst_busy0", 32'(b0.busy), 32'h0);
        check("rst_data1", b1.dsp_data, 32'h0);
        idle(2);

        strobe(8'h00); idle(40);
        strobe(8'hFF); idle(40);
        strobe(8'h80); idle(40);
        strobe(8'h01); idle(40);
        strobe(8'h7F); idle(40);

        // Drop during conversion and on the DONE cycle, accept right after.
        strobe(8'hFF); idle(4);
        strobe(8'h01); idle(28);
        strobe(8'h01);
        strobe(8'h01); idle(40);

        // Asynchronous reset pulse between clock edges mid-conversion.
        strobe(8'hFF); idle(9);
        #1;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        last_acc = -1000;
        #1;
        check("midrst_data0", b0.dsp_data, 32'h0);
        check("midrst_busy0", 32'(b0.busy), 32'h0);
        check("midrst_data1", b1.dsp_data, 32'h0);
        check("midrst_busy1", 32'(b1.busy), 32'h0);
        #1;
        rst = 1'b0;
        idle(3);
        strobe(8'h80); idle(40);

        for (int c = 0; c < 256; c++) begin
            strobe(8'(c));
            idle(34 + int'($urandom_range(0, 2)));
        end

        for (int i = 0; i < 40; i++) begin
            strobe(8'($urandom));
            idle(int'($urandom_range(0, 45)));
        end

        k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 100) begin
            idle(1);
            k++;
        end
        idle(2);
        if (q0.size() != 0 || q1.size() != 0) begin
            total++;
            $display("FAIL drain: %0d/%0d results outstanding, 0 required",
                     q0.size(), q1.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
